// File: rtl/fault_cam_if.sv
`default_nettype none
// ============================================================================
// Module   : fault_cam_if
// Brief    : Fault handshake and flattened CAM status bundle for fault_cam_ctrl
// Revision : 1.0
// ============================================================================
interface fault_cam_if #(
  parameter int ROW_W       = 10,
  parameter int COL_W       = 10,
  parameter int BANK_W      = 2,
  parameter int PCAM_DEPTH  = 8,
  parameter int NPCAM_DEPTH = 30
);
  localparam int PTR_W  = $clog2(PCAM_DEPTH);
  localparam int AW     = (ROW_W > COL_W) ? ROW_W : COL_W;
  localparam int NCNT_W = $clog2(NPCAM_DEPTH + 1);

  logic                            early_term;
  logic                            in_valid;
  logic                            in_ready;
  logic [ROW_W-1:0]                in_row;
  logic [COL_W-1:0]                in_col;
  logic [BANK_W-1:0]               in_bank;
  logic [PCAM_DEPTH-1:0]           pcam_valid;
  logic [PCAM_DEPTH*ROW_W-1:0]     pcam_row;
  logic [PCAM_DEPTH*COL_W-1:0]     pcam_col;
  logic [PCAM_DEPTH*BANK_W-1:0]    pcam_bank;
  logic [PCAM_DEPTH*2-1:0]         pcam_must;
  logic [NPCAM_DEPTH-1:0]          npcam_valid;
  logic [NPCAM_DEPTH*PTR_W-1:0]    npcam_ptr;
  logic [NPCAM_DEPTH-1:0]          npcam_desc;
  logic [NPCAM_DEPTH*AW-1:0]       npcam_addr;
  logic [NPCAM_DEPTH*BANK_W-1:0]   npcam_bank;
  logic [PTR_W:0]                  pcam_count;
  logic [NCNT_W-1:0]               npcam_count;
  logic                            unrepairable;
  logic                            busy;

  modport master (
    output early_term, in_valid, in_row, in_col, in_bank,
    input  in_ready, pcam_valid, pcam_row, pcam_col, pcam_bank, pcam_must,
           npcam_valid, npcam_ptr, npcam_desc, npcam_addr, npcam_bank,
           pcam_count, npcam_count, unrepairable, busy
  );

  modport slave (
    input  early_term, in_valid, in_row, in_col, in_bank,
    output in_ready, pcam_valid, pcam_row, pcam_col, pcam_bank, pcam_must,
           npcam_valid, npcam_ptr, npcam_desc, npcam_addr, npcam_bank,
           pcam_count, npcam_count, unrepairable, busy
  );
endinterface
`default_nettype wire

// File: rtl/fault_cam_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fault_cam_ctrl
// Brief    : Pivot/non-pivot fault CAM with must-repair and unrepairable detect
// Revision : 1.0
// ============================================================================
module fault_cam_ctrl #(
  parameter int ROW_W       = 10,
  parameter int COL_W       = 10,
  parameter int BANK_W      = 2,
  parameter int PCAM_DEPTH  = 8,
  parameter int NPCAM_DEPTH = 30,
  parameter int ROW_SPARE   = 2,
  parameter int COL_SPARE   = 2,
  parameter int SHARED_ROW  = 0
) (
  input  logic         clk,
  input  logic         rst,
  fault_cam_if.slave   bus
);
  localparam int PTR_W   = $clog2(PCAM_DEPTH);
  localparam int PCNT_W  = PTR_W + 1;
  localparam int AW      = (ROW_W > COL_W) ? ROW_W : COL_W;
  localparam int NCNT_W  = $clog2(NPCAM_DEPTH + 1);
  localparam int MAX_SP  = (ROW_SPARE > COL_SPARE) ? ROW_SPARE : COL_SPARE;
  localparam int CNT_W   = $clog2(MAX_SP + 2);
  localparam int ROW_THR = COL_SPARE + 1;
  localparam int COL_THR = ROW_SPARE + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_HALT   = 2'd2
  } state_t;

  state_t                        r_state;
  logic                          r_in_ready;
  logic                          r_busy;
  logic                          r_unrep;
  logic [ROW_W-1:0]              r_f_row;
  logic [COL_W-1:0]              r_f_col;
  logic [BANK_W-1:0]             r_f_bank;

  logic [PCAM_DEPTH-1:0]         r_pvalid;
  logic [PCAM_DEPTH*ROW_W-1:0]   r_prow;
  logic [PCAM_DEPTH*COL_W-1:0]   r_pcol;
  logic [PCAM_DEPTH*BANK_W-1:0]  r_pbank;
  logic [PCAM_DEPTH*2-1:0]       r_pmust;
  logic [CNT_W-1:0]              r_row_cnt [PCAM_DEPTH];
  logic [CNT_W-1:0]              r_col_cnt [PCAM_DEPTH];
  logic [PCNT_W-1:0]             r_pcount;

  logic [NPCAM_DEPTH-1:0]        r_nvalid;
  logic [NPCAM_DEPTH*PTR_W-1:0]  r_nptr;
  logic [NPCAM_DEPTH-1:0]        r_ndesc;
  logic [NPCAM_DEPTH*AW-1:0]     r_naddr;
  logic [NPCAM_DEPTH*BANK_W-1:0] r_nbank;
  logic [NCNT_W-1:0]             r_ncount;

  logic [PCAM_DEPTH-1:0]         w_prow;
  logic [PCAM_DEPTH-1:0]         w_pcol;
  logic [PCAM_DEPTH-1:0]         w_rmust;
  logic [PCAM_DEPTH-1:0]         w_cmust;
  logic                          w_dup;
  logic                          w_cov;
  logic                          w_any;
  logic [PTR_W-1:0]              w_lo;
  logic                          w_lo_row;
  logic [PTR_W-1:0]              w_np_ptr;
  logic [ROW_W-1:0]              w_np_row;
  logic [COL_W-1:0]              w_np_col;
  logic                          w_is_new;
  logic                          w_is_np;
  logic                          w_pfull;
  logic                          w_nfull;
  logic                          w_wr_p;
  logic                          w_wr_n;
  logic [PTR_W-1:0]              w_pidx;
  logic [CNT_W-1:0]              w_rc_nxt [PCAM_DEPTH];
  logic [CNT_W-1:0]              w_cc_nxt [PCAM_DEPTH];
  logic [PCAM_DEPTH-1:0]         w_rm_nxt;
  logic [PCAM_DEPTH-1:0]         w_cm_nxt;
  logic [31:0]                   w_rm_cnt;
  logic [31:0]                   w_cm_cnt;
  logic                          w_unrep_nxt;

  // Match and classification of the latched fault against the current CAM
  always_comb begin
    w_prow   = '0;
    w_pcol   = '0;
    w_rmust  = '0;
    w_cmust  = '0;
    w_dup    = 1'b0;
    w_np_ptr = '0;
    w_np_row = '0;
    w_np_col = '0;
    w_lo     = '0;
    for (int p = 0; p < PCAM_DEPTH; p++) begin
      w_rmust[p] = r_pmust[2*p+1];
      w_cmust[p] = r_pmust[2*p];
      w_prow[p]  = r_pvalid[p] && (r_prow[p*ROW_W +: ROW_W] == r_f_row) &&
                   ((SHARED_ROW != 0) || (r_pbank[p*BANK_W +: BANK_W] == r_f_bank));
      w_pcol[p]  = r_pvalid[p] && (r_pcol[p*COL_W +: COL_W] == r_f_col) &&
                   (r_pbank[p*BANK_W +: BANK_W] == r_f_bank);
      if (r_pvalid[p] && (r_prow[p*ROW_W +: ROW_W] == r_f_row) &&
          (r_pcol[p*COL_W +: COL_W] == r_f_col) &&
          (r_pbank[p*BANK_W +: BANK_W] == r_f_bank))
        w_dup = 1'b1;
    end
    // Non-pivots store only the non-shared coordinate; the rest comes from the pivot
    for (int n = 0; n < NPCAM_DEPTH; n++) begin
      w_np_ptr = r_nptr[n*PTR_W +: PTR_W];
      w_np_row = r_ndesc[n] ? r_naddr[n*AW +: ROW_W] : r_prow[w_np_ptr*ROW_W +: ROW_W];
      w_np_col = r_ndesc[n] ? r_pcol[w_np_ptr*COL_W +: COL_W] : r_naddr[n*AW +: COL_W];
      if (r_nvalid[n] && (w_np_row == r_f_row) && (w_np_col == r_f_col) &&
          (r_nbank[n*BANK_W +: BANK_W] == r_f_bank))
        w_dup = 1'b1;
    end
    for (int p = PCAM_DEPTH - 1; p >= 0; p--) begin
      if (w_prow[p] || w_pcol[p])
        w_lo = PTR_W'(p);
    end
  end

  assign w_cov    = |(w_prow & w_rmust) || |(w_pcol & w_cmust);
  assign w_any    = |(w_prow | w_pcol);
  assign w_lo_row = w_prow[w_lo];
  assign w_is_new = !w_dup && !w_cov && !w_any;
  assign w_is_np  = !w_dup && !w_cov && w_any;
  assign w_pfull  = (r_pcount == PCNT_W'(PCAM_DEPTH));
  assign w_nfull  = (r_ncount == NCNT_W'(NPCAM_DEPTH));
  assign w_wr_p   = w_is_new && !w_pfull;
  assign w_wr_n   = w_is_np && !w_nfull;
  assign w_pidx   = r_pcount[PTR_W-1:0];

  // Line counters and must-repair flags as they will stand after this update
  always_comb begin
    w_rm_nxt = '0;
    w_cm_nxt = '0;
    w_rm_cnt = '0;
    w_cm_cnt = '0;
    for (int p = 0; p < PCAM_DEPTH; p++) begin
      w_rc_nxt[p] = r_row_cnt[p];
      w_cc_nxt[p] = r_col_cnt[p];
      w_rm_nxt[p] = w_rmust[p];
      w_cm_nxt[p] = w_cmust[p];
      if (w_wr_n && w_prow[p] && (r_row_cnt[p] != '1))
        w_rc_nxt[p] = r_row_cnt[p] + CNT_W'(1);
      if (w_wr_n && w_pcol[p] && (r_col_cnt[p] != '1))
        w_cc_nxt[p] = r_col_cnt[p] + CNT_W'(1);
      if (w_wr_p && (w_pidx == PTR_W'(p))) begin
        w_rc_nxt[p] = CNT_W'(1);
        w_cc_nxt[p] = CNT_W'(1);
        w_rm_nxt[p] = 1'b0;
        w_cm_nxt[p] = 1'b0;
      end
      if (w_rc_nxt[p] >= CNT_W'(ROW_THR))
        w_rm_nxt[p] = 1'b1;
      if (w_cc_nxt[p] >= CNT_W'(COL_THR))
        w_cm_nxt[p] = 1'b1;
      w_rm_cnt = w_rm_cnt + {31'd0, w_rm_nxt[p]};
      w_cm_cnt = w_cm_cnt + {31'd0, w_cm_nxt[p]};
    end
  end

  assign w_unrep_nxt = r_unrep || (w_is_new && w_pfull) || (w_is_np && w_nfull) ||
                       (w_rm_cnt > 32'(ROW_SPARE)) || (w_cm_cnt > 32'(COL_SPARE));

  always_ff @(posedge clk) begin
    if (rst || bus.early_term) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
      r_unrep    <= 1'b0;
      r_f_row    <= '0;
      r_f_col    <= '0;
      r_f_bank   <= '0;
      r_pvalid   <= '0;
      r_prow     <= '0;
      r_pcol     <= '0;
      r_pbank    <= '0;
      r_pmust    <= '0;
      r_pcount   <= '0;
      r_nvalid   <= '0;
      r_nptr     <= '0;
      r_ndesc    <= '0;
      r_naddr    <= '0;
      r_nbank    <= '0;
      r_ncount   <= '0;
      for (int p = 0; p < PCAM_DEPTH; p++) begin
        r_row_cnt[p] <= '0;
        r_col_cnt[p] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_f_row    <= bus.in_row;
            r_f_col    <= bus.in_col;
            r_f_bank   <= bus.in_bank;
            r_state    <= S_UPDATE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_UPDATE: begin
          if (w_wr_p) begin
            r_pvalid[w_pidx]                 <= 1'b1;
            r_prow[w_pidx*ROW_W +: ROW_W]    <= r_f_row;
            r_pcol[w_pidx*COL_W +: COL_W]    <= r_f_col;
            r_pbank[w_pidx*BANK_W +: BANK_W] <= r_f_bank;
            r_pcount                         <= r_pcount + PCNT_W'(1);
          end
          if (w_wr_n) begin
            r_nvalid[r_ncount]                 <= 1'b1;
            r_nptr[r_ncount*PTR_W +: PTR_W]    <= w_lo;
            r_ndesc[r_ncount]                  <= !w_lo_row;
            r_naddr[r_ncount*AW +: AW]         <= w_lo_row ? AW'(r_f_col) : AW'(r_f_row);
            r_nbank[r_ncount*BANK_W +: BANK_W] <= r_f_bank;
            r_ncount                           <= r_ncount + NCNT_W'(1);
          end
          for (int p = 0; p < PCAM_DEPTH; p++) begin
            r_row_cnt[p]   <= w_rc_nxt[p];
            r_col_cnt[p]   <= w_cc_nxt[p];
            r_pmust[2*p+1] <= w_rm_nxt[p];
            r_pmust[2*p]   <= w_cm_nxt[p];
          end
          r_unrep    <= w_unrep_nxt;
          r_state    <= w_unrep_nxt ? S_HALT : S_IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
        S_HALT: begin
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.busy         = r_busy;
  assign bus.unrepairable = r_unrep;
  assign bus.pcam_valid   = r_pvalid;
  assign bus.pcam_row     = r_prow;
  assign bus.pcam_col     = r_pcol;
  assign bus.pcam_bank    = r_pbank;
  assign bus.pcam_must    = r_pmust;
  assign bus.pcam_count   = r_pcount;
  assign bus.npcam_valid  = r_nvalid;
  assign bus.npcam_ptr    = r_nptr;
  assign bus.npcam_desc   = r_ndesc;
  assign bus.npcam_addr   = r_naddr;
  assign bus.npcam_bank   = r_nbank;
  assign bus.npcam_count  = r_ncount;
endmodule
`default_nettype wire

// File: tb/tb_fault_cam_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fault_cam_ctrl
// Brief    : Directed self-checking bench; two instances differ only in SHARED_ROW
// Revision : 1.0
// ============================================================================
module tb_fault_cam_ctrl;
  localparam int ROW_W = 10;
  localparam int COL_W = 10;
  localparam int BANK_W = 2;
  localparam int PD = 8;
  localparam int ND = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  fault_cam_if #(.ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W), .PCAM_DEPTH(PD), .NPCAM_DEPTH(ND)) if0 ();
  fault_cam_if #(.ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W), .PCAM_DEPTH(PD), .NPCAM_DEPTH(ND)) if1 ();

  fault_cam_ctrl #(.ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W), .PCAM_DEPTH(PD), .NPCAM_DEPTH(ND),
                   .ROW_SPARE(2), .COL_SPARE(2), .SHARED_ROW(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  fault_cam_ctrl #(.ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W), .PCAM_DEPTH(PD), .NPCAM_DEPTH(ND),
                   .ROW_SPARE(2), .COL_SPARE(2), .SHARED_ROW(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  task automatic drive(input logic v, input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c,
                       input logic [BANK_W-1:0] b);
    if0.in_valid = v; if0.in_row = r; if0.in_col = c; if0.in_bank = b;
    if1.in_valid = v; if1.in_row = r; if1.in_col = c; if1.in_bank = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if0.early_term = 1'b0;
    if1.early_term = 1'b0;
    drive(1'b0, '0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c, input logic [BANK_W-1:0] b);
    int t = 0;
    while (if0.in_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20) begin
      n_total++;
      $display("FAIL send_timeout in_ready=%b required 1", if0.in_ready);
    end
    drive(1'b1, r, c, b);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, '0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (if0.pcam_valid !== '0) $display("FAIL rst_pvalid got %h req 0", if0.pcam_valid); else n_pass++;
    n_total++; if (if0.npcam_valid !== '0) $display("FAIL rst_nvalid got %h req 0", if0.npcam_valid); else n_pass++;
    n_total++; if (if0.pcam_row !== '0 || if0.pcam_must !== '0) $display("FAIL rst_prow_must got %h/%h req 0", if0.pcam_row, if0.pcam_must); else n_pass++;
    n_total++; if (if0.pcam_count !== 4'd0 || if0.npcam_count !== 5'd0) $display("FAIL rst_counts got %0d/%0d req 0/0", if0.pcam_count, if0.npcam_count); else n_pass++;
    n_total++; if (if0.in_ready !== 1'b1 || if0.busy !== 1'b0 || if0.unrepairable !== 1'b0)
      $display("FAIL rst_flags got rdy=%b busy=%b unrep=%b req 1/0/0", if0.in_ready, if0.busy, if0.unrepairable); else n_pass++;
  endtask

  task automatic test_single_pivot();
    do_reset();
    drive(1'b1, 10'd5, 10'd7, 2'd1);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, '0);
    n_total++; if (if0.in_ready !== 1'b0 || if0.busy !== 1'b1) $display("FAIL single_update_flags got rdy=%b busy=%b req 0/1", if0.in_ready, if0.busy); else n_pass++;
    n_total++; if (if0.pcam_valid !== 8'h00) $display("FAIL single_early_write got %h req 00", if0.pcam_valid); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (if0.pcam_valid !== 8'h01) $display("FAIL single_pvalid got %h req 01", if0.pcam_valid); else n_pass++;
    n_total++; if (if0.pcam_row[9:0] !== 10'd5 || if0.pcam_col[9:0] !== 10'd7 || if0.pcam_bank[1:0] !== 2'd1)
      $display("FAIL single_addr got %0d,%0d,%0d req 5,7,1", if0.pcam_row[9:0], if0.pcam_col[9:0], if0.pcam_bank[1:0]); else n_pass++;
    n_total++; if (if0.pcam_count !== 4'd1 || if0.npcam_count !== 5'd0 || if0.npcam_valid !== '0)
      $display("FAIL single_counts got %0d/%0d req 1/0", if0.pcam_count, if0.npcam_count); else n_pass++;
    n_total++; if (if0.in_ready !== 1'b1 || if0.busy !== 1'b0) $display("FAIL single_idle got rdy=%b busy=%b req 1/0", if0.in_ready, if0.busy); else n_pass++;
  endtask

  task automatic test_nonpivot();
    do_reset();
    send(10'd5, 10'd7, 2'd1);
    send(10'd5, 10'd9, 2'd1);
    send(10'd5, 10'd9, 2'd1);
    n_total++; if (if0.npcam_count !== 5'd1 || if0.npcam_valid[0] !== 1'b1) $display("FAIL np_dup_count got %0d req 1", if0.npcam_count); else n_pass++;
    n_total++; if (if0.npcam_ptr[2:0] !== 3'd0 || if0.npcam_desc[0] !== 1'b0 || if0.npcam_addr[9:0] !== 10'd9 || if0.npcam_bank[1:0] !== 2'd1)
      $display("FAIL np_entry0 got ptr=%0d desc=%b addr=%0d bank=%0d req 0,0,9,1", if0.npcam_ptr[2:0], if0.npcam_desc[0], if0.npcam_addr[9:0], if0.npcam_bank[1:0]); else n_pass++;
    n_total++; if (if0.pcam_count !== 4'd1) $display("FAIL np_pcount got %0d req 1", if0.pcam_count); else n_pass++;
    send(10'd8, 10'd7, 2'd1);
    n_total++; if (if0.npcam_count !== 5'd2 || if0.npcam_desc[1] !== 1'b1 || if0.npcam_addr[19:10] !== 10'd8 || if0.npcam_ptr[5:3] !== 3'd0)
      $display("FAIL np_col_entry got cnt=%0d desc=%b addr=%0d ptr=%0d req 2,1,8,0", if0.npcam_count, if0.npcam_desc[1], if0.npcam_addr[19:10], if0.npcam_ptr[5:3]); else n_pass++;
  endtask

  task automatic test_must_repair();
    do_reset();
    send(10'd3, 10'd4, 2'd0);
    send(10'd3, 10'd6, 2'd0);
    n_total++; if (if0.pcam_must[1:0] !== 2'b00) $display("FAIL must_early got %b req 00", if0.pcam_must[1:0]); else n_pass++;
    send(10'd3, 10'd8, 2'd0);
    n_total++; if (if0.pcam_must[1:0] !== 2'b10) $display("FAIL must_row got %b req 10", if0.pcam_must[1:0]); else n_pass++;
    send(10'd3, 10'd12, 2'd0);
    n_total++; if (if0.npcam_count !== 5'd2 || if0.pcam_count !== 4'd1 || if0.unrepairable !== 1'b0)
      $display("FAIL must_covered got np=%0d p=%0d unrep=%b req 2,1,0", if0.npcam_count, if0.pcam_count, if0.unrepairable); else n_pass++;
    do_reset();
    send(10'd1, 10'd5, 2'd0);
    send(10'd2, 10'd5, 2'd0);
    send(10'd3, 10'd5, 2'd0);
    n_total++; if (if0.pcam_must[1:0] !== 2'b01 || if0.npcam_desc[1:0] !== 2'b11 || if0.npcam_addr[19:10] !== 10'd3)
      $display("FAIL must_col got must=%b desc=%b addr=%0d req 01,11,3", if0.pcam_must[1:0], if0.npcam_desc[1:0], if0.npcam_addr[19:10]); else n_pass++;
  endtask

  task automatic test_must_unrepairable();
    do_reset();
    for (int r = 1; r <= 3; r++)
      for (int k = 0; k < 3; k++) begin
        if (r == 3 && k == 2) begin
          n_total++; if (if0.unrepairable !== 1'b0) $display("FAIL mu_before got %b req 0", if0.unrepairable); else n_pass++;
        end
        send(10'(r), 10'(r*10 + k), 2'd0);
      end
    n_total++; if (if0.unrepairable !== 1'b1 || if0.pcam_must[5:0] !== 6'b101010 || if0.npcam_count !== 5'd6)
      $display("FAIL mu_after got unrep=%b must=%b np=%0d req 1,101010,6", if0.unrepairable, if0.pcam_must[5:0], if0.npcam_count); else n_pass++;
  endtask

  task automatic test_shared_row();
    do_reset();
    send(10'd3, 10'd4, 2'd0);
    send(10'd3, 10'd6, 2'd2);
    n_total++; if (if1.npcam_count !== 5'd1 || if1.pcam_count !== 4'd1 || if1.npcam_ptr[2:0] !== 3'd0 || if1.npcam_desc[0] !== 1'b0 || if1.npcam_bank[1:0] !== 2'd2)
      $display("FAIL shared_np got np=%0d p=%0d ptr=%0d desc=%b bank=%0d req 1,1,0,0,2", if1.npcam_count, if1.pcam_count, if1.npcam_ptr[2:0], if1.npcam_desc[0], if1.npcam_bank[1:0]); else n_pass++;
    n_total++; if (if0.pcam_count !== 4'd2 || if0.npcam_count !== 5'd0)
      $display("FAIL unshared_p got p=%0d np=%0d req 2,0", if0.pcam_count, if0.npcam_count); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [PD*ROW_W-1:0] exp_row;
    exp_row = '0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(10'(10 + i), 10'(20 + i), 2'd0);
      exp_row[i*ROW_W +: ROW_W] = 10'(10 + i);
    end
    n_total++; if (if0.pcam_count !== 4'd8 || if0.unrepairable !== 1'b0) $display("FAIL ovf_full got p=%0d unrep=%b req 8,0", if0.pcam_count, if0.unrepairable); else n_pass++;
    send(10'd18, 10'd28, 2'd0);
    n_total++; if (if0.unrepairable !== 1'b1 || if0.pcam_count !== 4'd8 || if0.pcam_row !== exp_row)
      $display("FAIL ovf_ninth got unrep=%b p=%0d req 1,8", if0.unrepairable, if0.pcam_count); else n_pass++;
    n_total++; if (if0.in_ready !== 1'b1 || if0.busy !== 1'b0) $display("FAIL ovf_halt_rdy got rdy=%b busy=%b req 1/0", if0.in_ready, if0.busy); else n_pass++;
    send(10'd1, 10'd1, 2'd1);
    n_total++; if (if0.pcam_count !== 4'd8 || if0.pcam_row !== exp_row || if0.npcam_count !== 5'd0 || if0.in_ready !== 1'b1 || if0.unrepairable !== 1'b1)
      $display("FAIL ovf_discard got p=%0d np=%0d rdy=%b unrep=%b req 8,0,1,1", if0.pcam_count, if0.npcam_count, if0.in_ready, if0.unrepairable); else n_pass++;
    if0.early_term = 1'b1; if1.early_term = 1'b1;
    @(posedge clk); #1;
    if0.early_term = 1'b0; if1.early_term = 1'b0;
    n_total++; if (if0.pcam_valid !== '0 || if0.pcam_row !== '0 || if0.pcam_count !== 4'd0 || if0.unrepairable !== 1'b0 || if0.in_ready !== 1'b1)
      $display("FAIL ovf_eterm got pv=%h p=%0d unrep=%b rdy=%b req 0,0,0,1", if0.pcam_valid, if0.pcam_count, if0.unrepairable, if0.in_ready); else n_pass++;
    send(10'd2, 10'd2, 2'd0);
    n_total++; if (if0.pcam_count !== 4'd1 || if0.pcam_valid !== 8'h01) $display("FAIL ovf_resume got p=%0d req 1", if0.pcam_count); else n_pass++;
  endtask

  task automatic test_rst_mid_update();
    do_reset();
    drive(1'b1, 10'd5, 10'd7, 2'd1);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, '0);
    n_total++; if (if0.busy !== 1'b1) $display("FAIL rmid_busy got %b req 1", if0.busy); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++; if (if0.pcam_valid !== '0 || if0.pcam_count !== 4'd0 || if0.in_ready !== 1'b1 || if0.busy !== 1'b0)
      $display("FAIL rmid_clear got pv=%h p=%0d rdy=%b busy=%b req 0,0,1,0", if0.pcam_valid, if0.pcam_count, if0.in_ready, if0.busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 10'd2, 10'd2, 2'd0);
    @(posedge clk); #1;
    n_total++; if (if0.in_ready !== 1'b0) $display("FAIL b2b_rdy0 got %b req 0", if0.in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (if0.in_ready !== 1'b1 || if0.pcam_count !== 4'd1) $display("FAIL b2b_first got rdy=%b p=%0d req 1,1", if0.in_ready, if0.pcam_count); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (if0.in_ready !== 1'b0 || if0.busy !== 1'b1) $display("FAIL b2b_reaccept got rdy=%b busy=%b req 0,1", if0.in_ready, if0.busy); else n_pass++;
    drive(1'b0, '0, '0, '0);
    @(posedge clk); #1;
    n_total++; if (if0.pcam_count !== 4'd1 || if0.npcam_count !== 5'd0) $display("FAIL b2b_dup got p=%0d np=%0d req 1,0", if0.pcam_count, if0.npcam_count); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_pivot();
    test_nonpivot();
    test_must_repair();
    test_must_unrepairable();
    test_shared_row();
    test_overflow();
    test_rst_mid_update();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fault_cam_ctrl.md
# fault_cam_ctrl

Parametrised pivot/non-pivot fault CAM with handshake input, must-repair detection and unrepairable early-termination for the BIRA datapath. It sits between the BIST fault collector and the redundancy-analysis solver. Each fault (row, col, bank) is classified as one of: pivot, non-pivot linked to a pivot, duplicate, or covered by a must-repair line. Full CAM contents and status are exposed as flattened vectors.

## Interface
- ROW_W, 10, row address width
- COL_W, 10, column address width
- BANK_W, 2, bank address width
- PCAM_DEPTH, 8, pivot entries; PTR_W = $clog2(PCAM_DEPTH)
- NPCAM_DEPTH, 30, non-pivot entries; AW = max(ROW_W, COL_W)
- ROW_SPARE, 2, spare rows available
- COL_SPARE, 2, spare columns available
- SHARED_ROW, 0, 1: a row spare spans all banks, so row match ignores bank

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- early_term  in  1  synchronous clear, same effect as rst
- in_valid  in  1  fault offered
- in_ready  out  1  fault accepted when in_valid & in_ready
- in_row / in_col / in_bank  in  ROW_W / COL_W / BANK_W  fault address
- pcam_valid  out  PCAM_DEPTH  entry valid
- pcam_row / pcam_col / pcam_bank  out  PCAM_DEPTH×ROW_W / ×COL_W / ×BANK_W  pivot address
- pcam_must  out  PCAM_DEPTH×2  {row_must, col_must}
- npcam_valid  out  NPCAM_DEPTH  entry valid
- npcam_ptr  out  NPCAM_DEPTH×PTR_W  linked pivot index
- npcam_desc  out  NPCAM_DEPTH  0 = shares row, 1 = shares column
- npcam_addr  out  NPCAM_DEPTH×AW  non-shared address, zero-extended (col if desc=0, row if desc=1)
- npcam_bank  out  NPCAM_DEPTH×BANK_W  bank
- pcam_count / npcam_count  out  PTR_W+1 / $clog2(NPCAM_DEPTH+1)  occupancy
- unrepairable  out  1  sticky fail flag
- busy  out  1  high in UPDATE

## Operation
- FSM states: IDLE, UPDATE, HALT. Entry i of each vector occupies bits [i*W +: W].
- IDLE: in_ready=1. On a handshake, latch the fault and go to UPDATE.
- UPDATE: in_ready=0. Classify the latched fault, write all results at the end of the cycle, then go to IDLE, or to HALT if unrepairable is set.
- Row match with pivot p: rows equal, and either SHARED_ROW or banks equal. Column match: columns equal and banks equal.
- Classification, first rule wins:
  - (a) Exact address equals any valid pivot or any non-pivot (reconstructed address): drop.
  - (b) Row matches a pivot with row_must=1, or column matches a pivot with col_must=1: drop as covered.
  - (c) Any pivot matches: write the non-pivot at npcam_count. ptr = lowest matching pivot index. desc=0 if that pivot matches by row, else 1.
  - (d) No match: write a new pivot at pcam_count.
- Counters (internal, per pivot): row_cnt and col_cnt. Both load 1 on pivot write and saturate.
  - On (c), increment row_cnt of every row-matching pivot and col_cnt of every column-matching pivot.
  - row_must sets when row_cnt reaches COL_SPARE+1. col_must sets when col_cnt reaches ROW_SPARE+1.
- unrepairable sets (sticky) on any of:
  - (d) with PCAM full
  - (c) with NPCAM full
  - number of set row_must flags > ROW_SPARE
  - number of set col_must flags > COL_SPARE
- A fault that overflows is not written.
- HALT: in_ready=1 and faults are discarded. Only rst or early_term leave HALT.

## Timing
- Reset values: every output vector 0, in_ready=1, busy=0, unrepairable=0, FSM = IDLE, counters 0.
- rst/early_term dominate in any state, including mid-UPDATE: the latched fault is lost. in_ready=1 the cycle after.
- Latency: handshake at edge N. CAM outputs, counts and flags update at edge N+1. in_ready is low during the cycle between.
- Throughput: one fault per 2 cycles.
- A held in_valid is accepted again only after in_ready returns high.

## Test plan
- Reset then one fault (5,7,1): at N+1, pcam_valid[0]=1, row=5, col=7, bank=1, pcam_count=1, npcam empty.
- Faults (5,7,1), (5,9,1), (5,9,1): entry npcam[0] has ptr=0, desc=0, addr=9, bank=1. The third fault is a duplicate, so npcam_count stays 1.
- Faults (3,4,0), (3,6,0), (3,8,0): pcam_must[0]=2'b10. A further (3,12,0) is dropped as covered, npcam_count=2.
- SHARED_ROW=1: faults (3,4,0), (3,6,2): npcam ptr=0, desc=0, bank=2. With SHARED_ROW=0 the same pair gives 2 pivots.
- Nine distinct non-matching faults: the ninth sets unrepairable, pcam_count=8, FSM=HALT. Next fault accepted with in_ready=1 and CAM unchanged. early_term clears all outputs.
- rst asserted during UPDATE: no write occurs, all outputs 0 next cycle.
